load_store_unit: RTL and testbench
==================================

# load_store_unit

Sub-word load/store front end between the core's memory-stage request and the word-organised data memory (1024 × 32-bit, combinational read, write on rising `clk`). It accepts one request at a time through a valid/ready handshake and performs little-endian byte/half/word lane selection. Loads are sign- or zero-extended. Byte and half stores use read-modify-write, and misaligned accesses are trapped without touching memory. The datapath consumes a single-cycle `rsp_valid` pulse.

## Interface
- `WORD_ADDR_BITS`, 10, number of word-index bits passed to memory (word index = `addr[WORD_ADDR_BITS+1:2]`)
- `clk` in 1: clock, all state updates on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: unit idle, request accepted when `req_valid & req_ready` at a rising edge
- `req_we` in 1: 1 = store, 0 = load
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word
- `req_unsigned` in 1: loads only, 1 = zero-extend
- `req_addr` in 32: byte address
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0])
- `rsp_valid` out 1: one-cycle completion pulse
- `rsp_rdata` out 32: extended load data; 0 for stores and traps
- `rsp_misaligned` out 1: valid with `rsp_valid`; access was misaligned and not performed
- `mem_write` out 1: to memory write enable
- `mem_addr` out 32: to memory address, always word-aligned `{addr[31:2],2'b00}`
- `mem_wdata` out 32: to memory write data
- `mem_rdata` in 32: from memory combinational read data

## Operation
- **States:** IDLE, READ, WRITE, RESP. Reset puts the FSM in IDLE.
- **IDLE**
  - `req_ready` = 1.
  - On accept, latch `we`, `size`, `unsigned`, `addr`, and `wdata`.
  - Misaligned (half with `addr[0]`=1, or word with `addr[1:0]`≠0): go to RESP with the trap flag set.
  - Load: go to READ.
  - Word store: go to WRITE with merged word = `wdata`.
  - Byte/half store: go to READ.
- **READ**
  - Drive `mem_addr` from the latched address; `mem_write` = 0.
  - Register `mem_rdata` into the read buffer at the edge.
  - Load: go to RESP. Store: go to WRITE.
- **WRITE**
  - `mem_write` = 1 for exactly this cycle.
  - `mem_wdata` = merged word: the read buffer with the target lane replaced.
  - Go to RESP.
- **RESP**
  - `rsp_valid` = 1; `rsp_rdata` and `rsp_misaligned` are valid.
  - Go to IDLE.
- **Lanes:**
  - Byte k = `addr[1:0]` occupies bits [8k+7:8k].
  - Half h = `addr[1]` occupies bits [16h+15:16h].
  - Store data beyond the access width is ignored.
- **Extension:**
  - Signed loads replicate the lane MSB into the upper bits.
  - Unsigned loads zero-fill the upper bits.
  - Word loads are never extended.
- `req_valid` while busy: ignored (`req_ready` = 0); no queueing.
- **Reset mid-operation:** `rst_n` low forces IDLE asynchronously and drops `mem_write` immediately. A pending RMW write is abandoned with no partial write, and no `rsp_valid` is generated.

## Timing
- **Reset values:** `req_ready` 1, `rsp_valid` 0, `rsp_rdata` 0, `rsp_misaligned` 0, `mem_write` 0, `mem_addr` 0, `mem_wdata` 0.
- **Latency** from the accept edge to `rsp_valid` high:
  - Misaligned trap: 1 cycle.
  - Word store: 2 cycles.
  - Load: 2 cycles.
  - Byte/half store: 3 cycles.
- Next accept is possible in the cycle after RESP, because IDLE asserts `req_ready`. Minimum spacing between accepts is latency + 1 cycles.
- The memory write commits on the rising edge that ends the WRITE cycle. A following load therefore reads the new data.
- All outputs are registered or decoded from the registered state only; there is no combinational path from `req_*` to `mem_*`.

## Test plan
- Preload word 0 = 0xCAD9C562:
  - lb @0x0 → `rsp_rdata` 0x00000062.
  - lb @0x3 → 0xFFFFFFCA.
  - lbu @0x3 → 0x000000CA.
  - Each: `rsp_valid` 2 cycles after accept, `mem_write` never high.
- lh @0x2 → 0xFFFFCAD9; lhu @0x2 → 0x0000CAD9; lw @0x0 → 0xCAD9C562.
- sb @0x1 with `wdata` 0x123456AB → exactly one `mem_write` pulse. A subsequent lw @0x0 returns 0xCAD9AB62. The store's `rsp_valid` comes 3 cycles after accept.
- sh @0x3 and lw @0x2 → `rsp_misaligned` 1 one cycle after accept, `rsp_rdata` 0, no `mem_write`, memory unchanged.
- sw @0x14 with 0xDEADBEEF → `mem_write` for 1 cycle with `mem_addr` 0x14. `req_valid` held high during busy cycles is not accepted; the next accept happens only when `req_ready` is 1.
- Assert `rst_n` low during READ of an sb → outputs return to reset values immediately, no `mem_write` pulse, memory word unchanged, and a new request is accepted after release.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// slave is the unit's view; master is the core/memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Sub-word load/store front end: little-endian lane select, load extension,
// read-modify-write for byte/half stores and trapping of misaligned accesses.
module load_store_unit #(
  parameter int WORD_ADDR_BITS = 10
) (
  input logic                clk,
  input logic                rst_n,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        we_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        mis_r;
  logic [31:0] rbuf_r;
  logic        accept_s;
  logic        mis_s;

  // Select the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] ofs, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {ofs, 3'b000});
    h = 16'(word >> {ofs[1], 4'b0000});
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the old word with right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] ofs);
    logic [31:0] mask;
    logic [31:0] data;
    logic [31:0] r;
    case (size)
      2'b00: begin
        mask = 32'h000000FF << {ofs, 3'b000};
        data = {24'h000000, wdata[7:0]} << {ofs, 3'b000};
        r    = (old & ~mask) | data;
      end
      2'b01: begin
        mask = 32'h0000FFFF << {ofs[1], 4'b0000};
        data = {16'h0000, wdata[15:0]} << {ofs[1], 4'b0000};
        r    = (old & ~mask) | data;
      end
      default: begin
        mask = 32'hFFFFFFFF;
        data = wdata;
        r    = data;
      end
    endcase
    return r;
  endfunction

  assign accept_s = (state_r == ST_IDLE) && bus.req_valid;
  assign mis_s    = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          next_state_s = ST_IDLE;
        end else if (mis_s) begin
          next_state_s = ST_RESP;
        end else if (bus.req_we && bus.req_size[1]) begin
          next_state_s = ST_WRITE;
        end else begin
          next_state_s = ST_READ;
        end
      end
      ST_READ: begin
        if (we_r) begin
          next_state_s = ST_WRITE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      ST_WRITE: next_state_s = ST_RESP;
      ST_RESP:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Request capture on accept and read-buffer load in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      uns_r   <= 1'b0;
      addr_r  <= 32'h00000000;
      wdata_r <= 32'h00000000;
      mis_r   <= 1'b0;
      rbuf_r  <= 32'h00000000;
    end else begin
      if (accept_s) begin
        we_r    <= bus.req_we;
        size_r  <= bus.req_size;
        uns_r   <= bus.req_unsigned;
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
        mis_r   <= mis_s;
      end
      if (state_r == ST_READ) begin
        rbuf_r <= bus.mem_rdata;
      end
    end
  end

  // Outputs decoded from registered state only; nothing flows from req_* to mem_*.
  always_comb begin
    bus.req_ready      = (state_r == ST_IDLE);
    bus.rsp_valid      = (state_r == ST_RESP);
    bus.rsp_misaligned = (state_r == ST_RESP) && mis_r;
    bus.mem_write      = (state_r == ST_WRITE);
    bus.mem_addr       = {addr_r[31:WORD_ADDR_BITS+2], addr_r[WORD_ADDR_BITS+1:2], 2'b00};
    bus.mem_wdata      = store_merge(rbuf_r, wdata_r, size_r, addr_r[1:0]);
    if ((state_r == ST_RESP) && !we_r && !mis_r) begin
      bus.rsp_rdata = load_extend(rbuf_r, size_r, addr_r[1:0], uns_r);
    end else begin
      bus.rsp_rdata = 32'h00000000;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 1024x32 data memory.
module tb_load_store_unit;
  localparam int WAB = 10;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   wr_pulses;
  logic [31:0] mem [0:(1<<WAB)-1];
  logic [31:0] waddr;
  int          w0;

  load_store_unit_if bus();

  load_store_unit #(.WORD_ADDR_BITS(WAB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[WAB+1:2]];

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr[WAB+1:2]] <= bus.mem_wdata;
      wr_pulses <= wr_pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and check latency, response data, trap flag and write pulses.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic [31:0] exp_rdata, input logic exp_mis,
                         input int exp_writes, input bit hold_valid,
                         output logic [31:0] got_waddr);
    int   lat;
    int   writes;
    logic seen;
    logic [31:0] rdata;
    logic mis;
    lat = 1; writes = 0; seen = 1'b0; rdata = 32'h0; mis = 1'b0; got_waddr = 32'hFFFFFFFF;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    check($sformatf("%s ready", tag), {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    if (!hold_valid) bus.req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.mem_write) begin
        writes++;
        got_waddr = bus.mem_addr;
      end
      if (bus.rsp_valid) begin
        seen  = 1'b1;
        rdata = bus.rsp_rdata;
        mis   = bus.rsp_misaligned;
        break;
      end
      if (hold_valid) check($sformatf("%s busy ready", tag), {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s rsp seen", tag), {31'd0, seen}, 32'd1);
    check($sformatf("%s latency", tag), lat, exp_lat);
    check($sformatf("%s rdata", tag), rdata, exp_rdata);
    check($sformatf("%s misaligned", tag), {31'd0, mis}, {31'd0, exp_mis});
    check($sformatf("%s writes", tag), writes, exp_writes);
    @(posedge clk); #1;
    check($sformatf("%s rsp pulse", tag), {31'd0, bus.rsp_valid}, 32'd0);
    check($sformatf("%s idle ready", tag), {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s req_ready", tag), {31'd0, bus.req_ready}, 32'd1);
    check($sformatf("%s rsp_valid", tag), {31'd0, bus.rsp_valid}, 32'd0);
    check($sformatf("%s rsp_rdata", tag), bus.rsp_rdata, 32'h0);
    check($sformatf("%s rsp_mis", tag), {31'd0, bus.rsp_misaligned}, 32'd0);
    check($sformatf("%s mem_write", tag), {31'd0, bus.mem_write}, 32'd0);
    check($sformatf("%s mem_addr", tag), bus.mem_addr, 32'h0);
    check($sformatf("%s mem_wdata", tag), bus.mem_wdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0; wr_pulses = 0;
    for (int i = 0; i < (1 << WAB); i++) mem[i] = 32'h0;
    mem[0] = 32'hCAD9C562;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Loads from the preloaded word.
    run_req("lb0",   1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2, 32'h00000062, 1'b0, 0, 1'b0, waddr);
    run_req("lb3",   1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 2, 32'hFFFFFFCA, 1'b0, 0, 1'b0, waddr);
    run_req("lbu3",  1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 2, 32'h000000CA, 1'b0, 0, 1'b0, waddr);
    run_req("lb1",   1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 2, 32'hFFFFFFC5, 1'b0, 0, 1'b0, waddr);
    run_req("lbu2",  1'b0, 2'b00, 1'b1, 32'h2, 32'h0, 2, 32'h000000D9, 1'b0, 0, 1'b0, waddr);
    run_req("lh2",   1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 2, 32'hFFFFCAD9, 1'b0, 0, 1'b0, waddr);
    run_req("lhu2",  1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 2, 32'h0000CAD9, 1'b0, 0, 1'b0, waddr);
    run_req("lh0",   1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 2, 32'hFFFFC562, 1'b0, 0, 1'b0, waddr);
    run_req("lw0",   1'b0, 2'b10, 1'b1, 32'h0, 32'h0, 2, 32'hCAD9C562, 1'b0, 0, 1'b0, waddr);

    // Byte store read-modify-write.
    run_req("sb1",   1'b1, 2'b00, 1'b0, 32'h1, 32'h123456AB, 3, 32'h0, 1'b0, 1, 1'b0, waddr);
    check("sb1 waddr", waddr, 32'h0);
    run_req("lw0b",  1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 2, 32'hCAD9AB62, 1'b0, 0, 1'b0, waddr);
    run_req("lsz3",  1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 2, 32'hCAD9AB62, 1'b0, 0, 1'b0, waddr);

    // Misaligned traps leave memory alone.
    run_req("sh3",   1'b1, 2'b01, 1'b0, 32'h3, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 0, 1'b0, waddr);
    run_req("lw2",   1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 1, 32'h0, 1'b1, 0, 1'b0, waddr);
    check("trap mem0", mem[0], 32'hCAD9AB62);

    // Upper-half store into a zero word.
    run_req("sh6",   1'b1, 2'b01, 1'b0, 32'h6, 32'hFFFF1234, 3, 32'h0, 1'b0, 1, 1'b0, waddr);
    check("sh6 waddr", waddr, 32'h4);
    check("sh6 mem1", mem[1], 32'h12340000);
    run_req("lhu6",  1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 2, 32'h00001234, 1'b0, 0, 1'b0, waddr);

    // Word store with req_valid held through the busy cycles.
    run_req("sw14",  1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 1'b1, waddr);
    check("sw14 waddr", waddr, 32'h14);
    check("sw14 mem5", mem[5], 32'hDEADBEEF);
    run_req("lw14",  1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 1'b0, waddr);

    // Reset during the READ cycle of a byte store.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h000000FF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rst busy ready", {31'd0, bus.req_ready}, 32'd0);
    w0 = wr_pulses;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    check("midrst no rsp", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    check("midrst writes", wr_pulses - w0, 32'd0);
    check("midrst mem0", mem[0], 32'hCAD9AB62);
    run_req("lw0c",  1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 2, 32'hCAD9AB62, 1'b0, 0, 1'b0, waddr);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
